// File: rtl/windows_pkg.sv
// -----------------------------------------------------------------------------
// windows_pkg
// Shared window types for the string-match path: ast_shift produces windows,
// windows_serializer narrows them to one per cycle, and the bloom-filter hash
// stage consumes them.  All three import this package so the byte width,
// default geometry and window/count types agree.
//
// Contents:
//   BYTE_W            bits per window byte
//   SYMBOLS_DEF       default byte lanes per input word
//   WINDOW_SIZE_DEF   default bytes per window
//   window_t          [WINDOW_SIZE_DEF][BYTE_W] window at default geometry
//   win_cnt_t         valid-byte count at default geometry (0 = empty)
//   clog2_min1()      $clog2 that never returns 0, for index widths
// -----------------------------------------------------------------------------
package windows_pkg;

   localparam int BYTE_W          = 8;
   localparam int SYMBOLS_DEF     = 8;
   localparam int WINDOW_SIZE_DEF = 20;

   // Index width that stays at least 1 bit for degenerate sizes.
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   localparam int WINDOW_SIZE_W_DEF = clog2_min1(WINDOW_SIZE_DEF);

   // Byte 0 is the window start.
   typedef logic [WINDOW_SIZE_DEF-1:0][BYTE_W-1:0] window_t;

   // One extra bit so a full window (count == WINDOW_SIZE) is representable.
   typedef logic [WINDOW_SIZE_W_DEF:0] win_cnt_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// -----------------------------------------------------------------------------
// prio_enc_lsb
// Lowest-set-bit priority encoder.  Also used by the hash-stage arbiter.
//
// Parameters:
//   WIDTH   request vector width
//   IDX_W   index width (derived, minimum 1)
// Ports:
//   req      in   [WIDTH]  request bits
//   idx      out  [IDX_W]  index of the lowest set bit (0 when none set)
//   onehot   out  [WIDTH]  mask with only the lowest set bit
//   any_set  out  1        at least one request bit is set
// -----------------------------------------------------------------------------
module prio_enc_lsb
   import windows_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = clog2_min1(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] onehot,
   output logic             any_set
);

   // Scan from the top down so the last hit written is the lowest bit.
   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end

   // Two's-complement trick isolates the lowest set bit.
   assign onehot  = req & (~req + WIDTH'(1));
   assign any_set = |req;

endmodule

// File: rtl/windows_serializer.sv
// -----------------------------------------------------------------------------
// windows_serializer
// Takes one multi-lane window word from ast_shift (one candidate window per
// input byte lane) and emits its non-empty windows one per cycle, lowest lane
// first, to the bloom-filter hash stage.
//
// Parameters:
//   SYMBOLS        byte lanes per input word
//   WINDOW_SIZE    bytes per window
//   WINDOW_SIZE_W  derived; count fields are WINDOW_SIZE_W+1 bits
//   LANE_W         derived lane index width
// Ports:
//   clk_i                  in   clock
//   srst_i                 in   synchronous active-high reset
//   windows_data_i         in   [SYMBOLS][WINDOW_SIZE][8] window bytes per lane
//   windows_valid_bytes_i  in   [SYMBOLS][WINDOW_SIZE_W+1] count per lane, 0 = empty
//   windows_ready_o        out  input word accepted this cycle (if present)
//   win_data_o             out  [WINDOW_SIZE][8] current window, bytes past count = 0
//   win_valid_bytes_o      out  byte count of current window, 0 when idle
//   win_lane_o             out  source lane of current window
//   win_valid_o            out  output window present
//   win_ready_i            in   downstream accepts
//
// The only state is the pending-lane mask plus the buffered word.  An empty
// mask means idle; otherwise the lowest pending lane is on the output.
// -----------------------------------------------------------------------------
module windows_serializer
   import windows_pkg::*;
#(
   parameter int SYMBOLS       = SYMBOLS_DEF,
   parameter int WINDOW_SIZE   = WINDOW_SIZE_DEF,
   parameter int WINDOW_SIZE_W = (WINDOW_SIZE == 1) ? 1 : $clog2(WINDOW_SIZE),
   parameter int LANE_W        = (SYMBOLS == 1) ? 1 : $clog2(SYMBOLS)
) (
   input  logic                                        clk_i,
   input  logic                                        srst_i,
   input  logic [SYMBOLS-1:0][WINDOW_SIZE-1:0][BYTE_W-1:0] windows_data_i,
   input  logic [SYMBOLS-1:0][WINDOW_SIZE_W:0]         windows_valid_bytes_i,
   output logic                                        windows_ready_o,
   output logic [WINDOW_SIZE-1:0][BYTE_W-1:0]          win_data_o,
   output logic [WINDOW_SIZE_W:0]                      win_valid_bytes_o,
   output logic [LANE_W-1:0]                           win_lane_o,
   output logic                                        win_valid_o,
   input  logic                                        win_ready_i
);

   typedef logic [WINDOW_SIZE-1:0][BYTE_W-1:0] win_t;
   typedef logic [WINDOW_SIZE_W:0]             cnt_t;

   localparam cnt_t MAX_CNT = cnt_t'(WINDOW_SIZE);

   // Buffered word.  Not reset: every byte reaching the output is gated by
   // the current count, which is 0 whenever nothing is pending.
   win_t [SYMBOLS-1:0]  data_q;
   cnt_t [SYMBOLS-1:0]  cnt_q;
   logic [SYMBOLS-1:0]  pending_q;

   logic [SYMBOLS-1:0]  lane_mask;
   cnt_t [SYMBOLS-1:0]  cnt_sat;
   logic                present;

   logic [LANE_W-1:0]   cur_lane;
   logic [SYMBOLS-1:0]  cur_oh;
   logic                any_pending;
   logic                last_window;
   logic                load;
   logic                out_fire;
   cnt_t                cur_cnt;

   // Per-lane occupancy and count saturation of the incoming word.
   for (genvar l = 0; l < SYMBOLS; l++) begin : g_lane
      assign lane_mask[l] = |windows_valid_bytes_i[l];
      assign cnt_sat[l]   = (windows_valid_bytes_i[l] > MAX_CNT) ? MAX_CNT
                                                                : windows_valid_bytes_i[l];
   end

   assign present = |lane_mask;

   prio_enc_lsb #(
      .WIDTH (SYMBOLS),
      .IDX_W (LANE_W)
   ) u_prio (
      .req     (pending_q),
      .idx     (cur_lane),
      .onehot  (cur_oh),
      .any_set (any_pending)
   );

   // The current lane is the only one left when clearing it empties the mask.
   assign last_window = any_pending && ((pending_q & ~cur_oh) == '0);

   // Combinational from win_ready_i: the next word may load on the same edge
   // the last window of this word leaves, so back-to-back words have no bubble.
   assign windows_ready_o = !srst_i && (!any_pending || (last_window && win_ready_i));

   // An all-empty word never counts as a transfer, even with ready high.
   assign load     = present && windows_ready_o;
   assign out_fire = any_pending && win_ready_i;

   // A load always wins over the clear: when both happen, the clear belonged
   // to the last lane of the old word and the new mask replaces it.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         pending_q <= '0;
      end else if (load) begin
         pending_q <= lane_mask;
      end else if (out_fire) begin
         pending_q <= pending_q & ~cur_oh;
      end
   end

   // load already excludes reset through windows_ready_o.
   always_ff @(posedge clk_i) begin
      if (load) begin
         data_q <= windows_data_i;
         cnt_q  <= cnt_sat;
      end
   end

   // Output mux.  Everything follows from pending_q and the buffer, so outputs
   // hold while stalled without extra registers.
   always_comb begin
      cur_cnt = any_pending ? cnt_q[cur_lane] : '0;
      for (int j = 0; j < WINDOW_SIZE; j++) begin
         // Bytes past the count are zeroed so downstream hashing is deterministic.
         win_data_o[j] = (cnt_t'(j) < cur_cnt) ? data_q[cur_lane][j] : '0;
      end
   end

   assign win_valid_bytes_o = cur_cnt;
   assign win_lane_o        = cur_lane;
   assign win_valid_o       = any_pending;

endmodule

// File: tb/tb_windows_serializer.sv
module tb_windows_serializer;

   localparam int SYM = 8;
   localparam int WS  = 20;
   localparam int CW  = 6;
   localparam int LW  = 3;

   typedef logic [SYM-1:0][CW-1:0] cnts_t;
   typedef logic [WS-1:0][7:0]     wbytes_t;

   // Expected window as the reference model sees it.
   typedef struct packed {
      logic [LW-1:0] lane;
      logic [CW-1:0] cnt;
      wbytes_t       data;
   } exp_t;

   typedef struct {
      cnts_t c;
      bit    rdy;
      bit    ev;
      int    el;
      int    ec;
      bit    ewr;
   } vec_t;

   logic clk = 1'b0;
   logic srst;
   logic [SYM-1:0][WS-1:0][7:0] din;
   cnts_t cin;
   logic rdy;
   logic windows_ready;
   wbytes_t win_data;
   logic [CW-1:0] win_cnt;
   logic [LW-1:0] win_lane;
   logic win_valid;

   int total = 0;
   int bad   = 0;

   exp_t q[$];
   vec_t tv[$];

   // Samples taken at the last negedge.
   logic s_v, s_wr;
   logic [LW-1:0] s_l;
   logic [CW-1:0] s_c;
   wbytes_t s_d;
   bit hold_prev = 0;
   logic [191:0] held;

   always #5 clk = ~clk;

   windows_serializer #(
      .SYMBOLS     (SYM),
      .WINDOW_SIZE (WS)
   ) dut (
      .clk_i                 (clk),
      .srst_i                (srst),
      .windows_data_i        (din),
      .windows_valid_bytes_i (cin),
      .windows_ready_o       (windows_ready),
      .win_data_o            (win_data),
      .win_valid_bytes_o     (win_cnt),
      .win_lane_o            (win_lane),
      .win_valid_o           (win_valid),
      .win_ready_i           (rdy)
   );

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: an accepted word becomes its non-empty lanes, ascending, each
   // clipped to WS bytes with the tail zeroed.
   task automatic push_word();
      exp_t e;
      for (int l = 0; l < SYM; l++) begin
         if (cin[l] != 0) begin
            e.lane = LW'(l);
            e.cnt  = (int'(cin[l]) > WS) ? CW'(WS) : cin[l];
            for (int j = 0; j < WS; j++)
               e.data[j] = (j < int'(e.cnt)) ? din[l][j] : 8'h00;
            q.push_back(e);
         end
      end
   endtask

   // Call at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic cycle(output bit acc);
      exp_t h;
      bit ev, ew, pres;
      logic [191:0] cur;
      @(negedge clk);
      pres = (cin != '0);
      ev   = (q.size() != 0);
      // Only the current word is ever queued, so one entry left = last window.
      ew   = !srst && (q.size() == 0 || (q.size() == 1 && rdy));
      s_v = win_valid; s_wr = windows_ready; s_l = win_lane; s_c = win_cnt; s_d = win_data;
      cur = 192'({s_l, s_c, s_d});
      chk("win_valid", 192'(s_v), 192'(ev));
      chk("windows_ready", 192'(s_wr), 192'(ew));
      if (ev) begin
         h = q[0];
         chk("win_lane", 192'(s_l), 192'(h.lane));
         chk("win_count", 192'(s_c), 192'(h.cnt));
         chk("win_data", 192'(s_d), 192'(h.data));
      end else begin
         chk("idle_count", 192'(s_c), 192'(0));
      end
      if (hold_prev) chk("stall_hold", cur, held);
      acc = pres && s_wr;
      @(posedge clk);
      hold_prev = s_v && !rdy && !srst;
      held = cur;
      if (srst) q.delete();
      else begin
         if (ev && rdy) void'(q.pop_front());
         if (pres && ew) push_word();
      end
      #1;
   endtask

   function automatic cnts_t mkc(input int l0, input int c0, input int l1, input int c1);
      cnts_t c = '0;
      if (l0 >= 0) c[l0] = CW'(c0);
      if (l1 >= 0) c[l1] = CW'(c1);
      return c;
   endfunction

   function automatic vec_t row(input cnts_t c, input bit r, input bit ev, input int el,
                                input int ec, input bit ewr);
      vec_t v;
      v.c = c; v.rdy = r; v.ev = ev; v.el = el; v.ec = ec; v.ewr = ewr;
      return v;
   endfunction

   function automatic wbytes_t pat(input int l, input int c);
      wbytes_t d;
      for (int j = 0; j < WS; j++) d[j] = (j < c) ? 8'(l * 32 + j + 1) : 8'h00;
      return d;
   endfunction

   initial begin
      bit acc;
      int vcnt;
      bit b_acc;
      cnts_t z, all20, cb, c4, c5;

      z = '0;
      for (int l = 0; l < SYM; l++) all20[l] = CW'(20);
      for (int l = 0; l < SYM; l++)
         for (int j = 0; j < WS; j++) din[l][j] = 8'(l * 32 + j + 1);
      c4 = mkc(1, 7, 6, 12);
      c5 = mkc(0, 5, -1, 0);

      // Full word, all lanes at 20.
      tv.push_back(row(all20, 1, 0, 0, 0, 1));
      for (int i = 0; i < SYM; i++) tv.push_back(row(z, 1, 1, i, 20, i == SYM - 1));
      tv.push_back(row(z, 1, 0, 0, 0, 1));
      // Lanes 2 and 5 only.
      tv.push_back(row(mkc(2, 3, 5, 20), 1, 0, 0, 0, 1));
      tv.push_back(row(z, 1, 1, 2, 3, 0));
      tv.push_back(row(z, 1, 1, 5, 20, 1));
      tv.push_back(row(z, 1, 0, 0, 0, 1));
      // Count 25 saturates; all-zero word is never taken.
      tv.push_back(row(mkc(4, 25, -1, 0), 1, 0, 0, 0, 1));
      tv.push_back(row(z, 1, 1, 4, 20, 1));
      tv.push_back(row(z, 0, 0, 0, 0, 1));
      tv.push_back(row(z, 1, 0, 0, 0, 1));
      // Backpressure with a competing word that must not load.
      tv.push_back(row(c4, 0, 0, 0, 0, 1));
      tv.push_back(row(c5, 0, 1, 1, 7, 0));
      tv.push_back(row(c5, 0, 1, 1, 7, 0));
      tv.push_back(row(c5, 1, 1, 1, 7, 0));
      tv.push_back(row(c5, 0, 1, 6, 12, 0));
      tv.push_back(row(z, 1, 1, 6, 12, 1));
      tv.push_back(row(z, 1, 0, 0, 0, 1));

      // Reset.
      srst = 1'b1; cin = '0; rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cycle(acc);
      chk("reset_lane", 192'(s_l), 192'(0));
      chk("reset_data", 192'(s_d), 192'(0));
      chk("reset_count", 192'(s_c), 192'(0));
      srst = 1'b0;

      // Table vectors.
      for (int i = 0; i < tv.size(); i++) begin
         cin = tv[i].c; rdy = tv[i].rdy;
         cycle(acc);
         chk("tv_valid", 192'(s_v), 192'(tv[i].ev));
         chk("tv_wready", 192'(s_wr), 192'(tv[i].ewr));
         chk("tv_count", 192'(s_c), tv[i].ev ? 192'(tv[i].ec) : 192'(0));
         if (tv[i].ev) begin
            chk("tv_lane", 192'(s_l), 192'(tv[i].el));
            chk("tv_data", 192'(s_d), 192'(pat(tv[i].el, tv[i].ec)));
         end
      end

      // Back-to-back: word A {0,3} then word B {1,2,7}; five windows, no bubble.
      cb = '0; cb[1] = CW'(4); cb[2] = CW'(20); cb[7] = CW'(1);
      cin = mkc(0, 20, 3, 9); rdy = 1'b1;
      cycle(acc);
      chk("b2b_load_a", 192'(acc), 192'(1));
      cin = cb; vcnt = 0; b_acc = 0;
      for (int k = 0; k < 6; k++) begin
         cycle(acc);
         if (s_v) vcnt++;
         if (acc) begin
            b_acc = 1;
            chk("b2b_load_b_cycle", 192'(k), 192'(1));
            cin = '0;
         end
      end
      chk("b2b_load_b", 192'(b_acc), 192'(1));
      chk("b2b_windows", 192'(vcnt), 192'(5));

      // Reset while lane 3 of 6 is on the output.
      cin = '0;
      for (int l = 0; l < 6; l++) cin[l] = CW'(l + 2);
      cycle(acc);
      cin = '0;
      repeat (3) cycle(acc);
      chk("pre_reset_lane", 192'(s_l), 192'(2));
      srst = 1'b1;
      cycle(acc);
      chk("mid_reset_lane", 192'(s_l), 192'(3));
      srst = 1'b0;
      cycle(acc);
      chk("post_reset_valid", 192'(s_v), 192'(0));
      cin = mkc(3, 5, 5, 20);
      cycle(acc);
      cin = '0;
      repeat (3) cycle(acc);
      chk("post_reset_drained", 192'(q.size()), 192'(0));

      // Random words with random backpressure.
      for (int w = 0; w < 1000; w++) begin
         for (int l = 0; l < SYM; l++) begin
            cin[l] = ($urandom_range(0, 1) != 0) ? CW'($urandom_range(1, 30)) : CW'(0);
            for (int j = 0; j < WS; j++) din[l][j] = 8'($urandom);
         end
         if (cin == '0) begin
            rdy = 1'($urandom_range(0, 1));
            cycle(acc);
            chk("rand_empty_taken", 192'(acc), 192'(0));
         end else begin
            acc = 0;
            for (int t = 0; t < 100 && !acc; t++) begin
               rdy = ($urandom_range(0, 3) != 0);
               cycle(acc);
            end
            chk("rand_accept_timeout", 192'(acc), 192'(1));
         end
      end
      cin = '0; rdy = 1'b1;
      repeat (12) cycle(acc);
      chk("rand_drained", 192'(q.size()), 192'(0));
      chk("rand_idle_valid", 192'(s_v), 192'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/windows_serializer.md
# windows_serializer

Converts the multi-lane window word produced by `ast_shift` (one candidate window per input byte lane per beat) into a single-window-per-cycle stream for the downstream bloom-filter hash/lookup stage. Registers one input word, drops empty lanes, and emits the remaining windows in ascending lane order under valid/ready flow control. Drives `ast_shift`'s `windows_ready_i` directly.

## Interface
- `SYMBOLS`, 8: byte lanes per input word (`AST_DATA_W/8`).
- `WINDOW_SIZE`, 20: bytes per window.
- `WINDOW_SIZE_W`, `(WINDOW_SIZE==1) ? 1 : $clog2(WINDOW_SIZE)`: derived; byte-count fields are `WINDOW_SIZE_W+1` bits.
- `LANE_W`, `(SYMBOLS==1) ? 1 : $clog2(SYMBOLS)`: derived.

Ports:
- `clk_i`  in  1  clock.
- `srst_i`  in  1  synchronous active-high reset.
- `windows_data_i`  in  `[SYMBOLS][WINDOW_SIZE][8]`  window bytes per lane; byte 0 is the window start.
- `windows_valid_bytes_i`  in  `[SYMBOLS][WINDOW_SIZE_W+1]`  valid bytes per lane; 0 = lane empty.
- `windows_ready_o`  out  1  input word accepted this cycle.
- `win_data_o`  out  `[WINDOW_SIZE][8]`  current window.
- `win_valid_bytes_o`  out  `WINDOW_SIZE_W+1`  byte count of current window.
- `win_lane_o`  out  `LANE_W`  source lane of current window.
- `win_valid_o`  out  1  output window present.
- `win_ready_i`  in  1  downstream accepts.

## Operation
- Input word is "present" when any lane count is non-zero. Input transfer: present && `windows_ready_o`. A word with all counts zero is ignored, whatever the state of `windows_ready_o`.
- Transfer loads the data buffer and `pending[SYMBOLS]`, where bit i = (count[i] != 0). Counts greater than `WINDOW_SIZE` saturate to `WINDOW_SIZE`.
- Output lane is the lowest set bit of `pending`. `win_valid_o = |pending`. `win_lane_o` is that lane's index.
- `win_data_o` carries that lane's bytes. Bytes at index >= count are forced to 0x00, so downstream hashing is deterministic.
- `win_valid_bytes_o` is forced to 0 when `win_valid_o` = 0.
- Output transfer: `win_valid_o && win_ready_i` clears the current lane's bit.
- `windows_ready_o = !srst_i && (pending == 0 || (pending is one-hot && win_ready_i))`. This is a combinational path from `win_ready_i`. It allows a new word to load in the same cycle the last window of the previous word leaves.
- No state machine beyond `pending`: empty (pending == 0) / draining (pending != 0).

## Timing
- Reset values: `pending` = 0; `win_valid_o` = 0; `win_valid_bytes_o` = 0; `win_lane_o` = 0; `windows_ready_o` = 0 while `srst_i` is high. Data buffer is not reset; it is masked to 0 by the zeroing rule.
- Latency: an input transfer at edge N gives `win_valid_o` = 1 from cycle N+1.
- Throughput: one window per cycle while `win_ready_i` = 1. A word with k non-empty lanes occupies k cycles, back-to-back with the next word.
- Backpressure: while `win_valid_o` = 1 and `win_ready_i` = 0, all `win_*` outputs hold stable.
- Simultaneous last-window output and new-word input: the new word loads, and `pending` becomes the new mask rather than 0. There is no bubble.
- Reset mid-drain: the buffered word is discarded and `win_valid_o` = 0 on the next cycle.

## Structure
- Shared package `windows_pkg`: `BYTE_W` = 8 and the window types `window_t` (`[WINDOW_SIZE][BYTE_W]`) and the count type. `ast_shift` and the hash stage import the same types.
- Sub-module `prio_enc_lsb` (parameter `WIDTH`): outputs the lowest-set-bit index, a one-hot mask of that bit, and an any-set flag. It is reused by the hash-stage arbiter.

## Test plan
- Single word, all 8 lanes with count 20, `win_ready_i` = 1: 8 windows on consecutive cycles, lanes 0..7. `windows_ready_o` = 1 in the 8th output cycle.
- Lanes 2 and 5 only (counts 3 and 20): 2 windows (lane 2, count 3, bytes 3..19 = 0x00; then lane 5, count 20). Lanes with count 0 never appear.
- Back-to-back words with `win_ready_i` = 1: no idle cycle between the last window of word A and the first of word B. Total cycles equal the total non-empty lanes + 1.
- Random `win_ready_i` for 1000 words: output window multiset equals the input multiset. Outputs hold stable while stalled, and no windows are duplicated or dropped.
- Count 25 with `WINDOW_SIZE` = 20 -> `win_valid_bytes_o` = 20. All-zero counts -> no transfer and `win_valid_o` stays 0.
- `srst_i` pulsed while draining lane 3 of 6: `win_valid_o` = 0 the next cycle and no stale windows appear. The next word drains normally.
